// File: rtl/rs232_mem_ctrl.sv
// rs232_mem_ctrl: byte-framed command decoder between UART RX/TX and a 256x8 memory; RS232_MEM_CTRL_CKSUM_EN adds a trailing XOR checksum byte.
// Latency: memory write 1 cycle after the last frame byte; read response valid 3 cycles after it.
// Backpressure: tx_valid/tx_data held until tx_ready; bytes arriving while a frame is being executed are dropped with err.
module rs232_mem_ctrl #(
   parameter logic [7:0]  CMD_WR      = 8'h57,
   parameter logic [7:0]  CMD_RD      = 8'h52,
   parameter logic [7:0]  ACK_BYTE    = 8'h06,
   parameter logic [7:0]  NAK_BYTE    = 8'h15,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [7:0] mem_addr,
   output logic       mem_write,
   output logic [7:0] mem_data_in,
   input  logic [7:0] mem_data_out,
   output logic       busy,
   output logic       err
);

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

`ifdef RS232_MEM_CTRL_CKSUM_EN
   typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, MEM_WR, MEM_RD, MEM_CAP, TX_SEND, GET_CKSUM} state_t;
`else
   typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, MEM_WR, MEM_RD, MEM_CAP, TX_SEND} state_t;
`endif

   state_t      state, nxt_state;
   logic [7:0]  opcode, nxt_opcode;
   logic [7:0]  addr_q, nxt_addr;
   logic [7:0]  data_q, nxt_data;
   logic [15:0] tmo_cnt, nxt_tmo;
   logic [7:0]  nxt_tx_data, nxt_mem_addr, nxt_mem_data_in;
   logic        nxt_tx_valid, nxt_mem_write, nxt_err;
   logic        in_frame;
`ifdef RS232_MEM_CTRL_CKSUM_EN
   logic [7:0]  cksum, nxt_cksum;
   assign in_frame = (state == GET_ADDR) || (state == GET_DATA) || (state == GET_CKSUM);
`else
   assign in_frame = (state == GET_ADDR) || (state == GET_DATA);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nxt_state;
   end

   always_comb begin
      nxt_state       = state;
      nxt_opcode      = opcode;
      nxt_addr        = addr_q;
      nxt_data        = data_q;
      nxt_tmo         = tmo_cnt;
      nxt_tx_data     = tx_data;
      nxt_tx_valid    = tx_valid;
      nxt_mem_addr    = mem_addr;
      nxt_mem_data_in = mem_data_in;
      nxt_mem_write   = 1'b0;
      nxt_err         = 1'b0;
`ifdef RS232_MEM_CTRL_CKSUM_EN
      nxt_cksum       = cksum;
`endif
      // Outputs are loaded on the edge that enters the state they belong to.
      case (state)
         IDLE: begin
            if (rx_valid) begin
               if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                  nxt_opcode = rx_data;
                  nxt_tmo    = '0;
                  nxt_state  = GET_ADDR;
`ifdef RS232_MEM_CTRL_CKSUM_EN
                  nxt_cksum  = rx_data;
`endif
               end else begin
                  nxt_tx_data  = NAK_BYTE;
                  nxt_tx_valid = 1'b1;
                  nxt_err      = 1'b1;
                  nxt_state    = TX_SEND;
               end
            end
         end
         GET_ADDR: begin
            if (rx_valid) begin
               nxt_addr = rx_data;
               nxt_tmo  = '0;
`ifdef RS232_MEM_CTRL_CKSUM_EN
               nxt_cksum = cksum ^ rx_data;
               nxt_state = (opcode == CMD_WR) ? GET_DATA : GET_CKSUM;
`else
               if (opcode == CMD_WR) begin
                  nxt_state = GET_DATA;
               end else begin
                  nxt_mem_addr = rx_data;
                  nxt_state    = MEM_RD;
               end
`endif
            end
         end
         GET_DATA: begin
            if (rx_valid) begin
               nxt_data = rx_data;
               nxt_tmo  = '0;
`ifdef RS232_MEM_CTRL_CKSUM_EN
               nxt_cksum = cksum ^ rx_data;
               nxt_state = GET_CKSUM;
`else
               nxt_mem_addr    = addr_q;
               nxt_mem_data_in = rx_data;
               nxt_mem_write   = 1'b1;
               nxt_state       = MEM_WR;
`endif
            end
         end
`ifdef RS232_MEM_CTRL_CKSUM_EN
         GET_CKSUM: begin
            if (rx_valid) begin
               nxt_tmo = '0;
               if (rx_data != cksum) begin
                  nxt_tx_data  = NAK_BYTE;
                  nxt_tx_valid = 1'b1;
                  nxt_err      = 1'b1;
                  nxt_state    = TX_SEND;
               end else if (opcode == CMD_WR) begin
                  nxt_mem_addr    = addr_q;
                  nxt_mem_data_in = data_q;
                  nxt_mem_write   = 1'b1;
                  nxt_state       = MEM_WR;
               end else begin
                  nxt_mem_addr = addr_q;
                  nxt_state    = MEM_RD;
               end
            end
         end
`endif
         MEM_WR: begin
            nxt_err      = rx_valid;
            nxt_tx_data  = ACK_BYTE;
            nxt_tx_valid = 1'b1;
            nxt_state    = TX_SEND;
         end
         MEM_RD: begin
            nxt_err   = rx_valid;
            nxt_state = MEM_CAP;
         end
         MEM_CAP: begin
            nxt_err      = rx_valid;
            nxt_tx_data  = mem_data_out;
            nxt_tx_valid = 1'b1;
            nxt_state    = TX_SEND;
         end
         TX_SEND: begin
            nxt_err = rx_valid;
            if (tx_ready) begin
               nxt_tx_valid = 1'b0;
               nxt_state    = IDLE;
            end
         end
         default: nxt_state = IDLE;
      endcase

      // Inter-byte timeout: a silent frame is abandoned without touching memory or replying.
      if (in_frame && !rx_valid) begin
         if (tmo_cnt == TMO_LAST) begin
            nxt_tmo   = '0;
            nxt_err   = 1'b1;
            nxt_state = IDLE;
         end else begin
            nxt_tmo = tmo_cnt + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         opcode      <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         tmo_cnt     <= '0;
         tx_data     <= '0;
         tx_valid    <= 1'b0;
         mem_addr    <= '0;
         mem_write   <= 1'b0;
         mem_data_in <= '0;
         busy        <= 1'b0;
         err         <= 1'b0;
`ifdef RS232_MEM_CTRL_CKSUM_EN
         cksum       <= '0;
`endif
      end else begin
         opcode      <= nxt_opcode;
         addr_q      <= nxt_addr;
         data_q      <= nxt_data;
         tmo_cnt     <= nxt_tmo;
         tx_data     <= nxt_tx_data;
         tx_valid    <= nxt_tx_valid;
         mem_addr    <= nxt_mem_addr;
         mem_write   <= nxt_mem_write;
         mem_data_in <= nxt_mem_data_in;
         busy        <= (nxt_state != IDLE);
         err         <= nxt_err;
`ifdef RS232_MEM_CTRL_CKSUM_EN
         cksum       <= nxt_cksum;
`endif
      end
   end

endmodule
